// File: rtl/cpu_arb_pkg.sv
// -----------------------------------------------------------------------------
// cpu_arb_pkg
// Shared types and constants for the mox125 fetch/data memory arbiter.
//   arb_state_t  : arbiter state encoding (ARB_IDLE, ARB_IF, ARB_DM)
//   ARB_SEL_WORD : byte-select used for every instruction fetch (full word)
//   STARVE_CNT_W : width of the fetch-starvation counter
// -----------------------------------------------------------------------------
package cpu_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_IF   = 2'b01,
        ARB_DM   = 2'b10
    } arb_state_t;

    localparam logic [3:0] ARB_SEL_WORD = 4'hF;

    localparam int unsigned STARVE_CNT_W = 4;

endpackage : cpu_arb_pkg

// File: rtl/cpu_arb_starve_ctr.sv
// -----------------------------------------------------------------------------
// cpu_arb_starve_ctr
// Counts data grants made while a fetch is waiting. Once the count reaches
// STARVE_LIMIT, force_if_o tells the arbiter to give the next grant to fetch.
// Only instantiated when CPU_ARB_STARVE_GUARD_EN is defined.
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset
//   arb_idle_i    : arbiter is in ARB_IDLE this cycle
//   if_req_i      : fetch request pending
//   if_grant_i    : fetch granted at this edge
//   dm_grant_i    : data granted at this edge
//   force_if_o    : registered, counter has reached STARVE_LIMIT
// -----------------------------------------------------------------------------
module cpu_arb_starve_ctr
    import cpu_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic arb_idle_i,
    input  logic if_req_i,
    input  logic if_grant_i,
    input  logic dm_grant_i,
    output logic force_if_o
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT_C = STARVE_CNT_W'(STARVE_LIMIT);

    logic [STARVE_CNT_W-1:0] cnt_r;
    logic [STARVE_CNT_W-1:0] cnt_nxt_s;
    logic                    force_r;

    // Next count: clear on fetch grant or idle without fetch, saturating increment
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (if_grant_i) begin
            cnt_nxt_s = '0;
        end else if (arb_idle_i && !if_req_i) begin
            cnt_nxt_s = '0;
        end else if (dm_grant_i && if_req_i && (cnt_r != LIMIT_C)) begin
            cnt_nxt_s = cnt_r + STARVE_CNT_W'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Counter and force flag registers; the flag always equals (cnt_r == limit)
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_r   <= '0;
            force_r <= 1'b0;
        end else begin
            cnt_r   <= cnt_nxt_s;
            force_r <= (cnt_nxt_s == LIMIT_C);
        end
    end

    assign force_if_o = force_r;

endmodule : cpu_arb_starve_ctr

// File: rtl/cpu_mem_arbiter.sv
// -----------------------------------------------------------------------------
// cpu_mem_arbiter
// Shares one Wishbone-style memory port between instruction fetch and the
// data memory stage. One bus transaction at a time; data has priority over
// fetch because the memory stage holds the older instruction. Fetch responses
// are dropped when a branch flush hits while the fetch is on the bus.
//
// Optional feature: define CPU_ARB_STARVE_GUARD_EN to compile in the fetch
// starvation guard (after STARVE_LIMIT consecutive data grants with a fetch
// waiting, fetch wins the next arbitration). Without it, priority is strictly
// data-first and STARVE_LIMIT has no effect.
//
// Ports:
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   if_req_i/if_adr_i            : fetch request and word address
//   if_dat_o/if_ack_o            : fetch read data and completion
//   flush_i                      : branch flush, discards in-flight fetch
//   dm_req_i/we/sel/adr/dat_i    : data request, write enable, lanes, addr, wdata
//   dm_dat_o/dm_ack_o            : data read data and completion
//   wb_cyc_o/stb/we/sel/adr/dat_o: registered bus master outputs
//   wb_dat_i/wb_ack_i            : bus read data and acknowledge
// -----------------------------------------------------------------------------
module cpu_mem_arbiter
    import cpu_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_req_i,
    input  logic [31:0] if_adr_i,
    output logic [31:0] if_dat_o,
    output logic        if_ack_o,
    input  logic        flush_i,
    input  logic        dm_req_i,
    input  logic        dm_we_i,
    input  logic [3:0]  dm_sel_i,
    input  logic [31:0] dm_adr_i,
    input  logic [31:0] dm_dat_i,
    output logic [31:0] dm_dat_o,
    output logic        dm_ack_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i
);

    arb_state_t  state_r;
    logic        discard_r;
    logic        wb_cyc_r;
    logic        wb_stb_r;
    logic        wb_we_r;
    logic [3:0]  wb_sel_r;
    logic [31:0] wb_adr_r;
    logic [31:0] wb_dat_r;

    logic        grant_dm_s;
    logic        grant_if_s;
    logic        force_if_s;

`ifdef CPU_ARB_STARVE_GUARD_EN
    cpu_arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .arb_idle_i (state_r == ARB_IDLE),
        .if_req_i   (if_req_i),
        .if_grant_i (grant_if_s),
        .dm_grant_i (grant_dm_s),
        .force_if_o (force_if_s)
    );
`else
    // Strict data priority: fetch is never forced. The parameter has no
    // function in this build and is only kept referenced here.
    logic unused_starve_limit_s;
    assign unused_starve_limit_s = ^STARVE_LIMIT;
    assign force_if_s            = 1'b0;
`endif

    // Arbitration: only in ARB_IDLE; data wins unless a waiting fetch is forced
    always_comb begin
        grant_dm_s = 1'b0;
        grant_if_s = 1'b0;
        if (state_r == ARB_IDLE) begin
            if (dm_req_i && !(force_if_s && if_req_i)) begin
                grant_dm_s = 1'b1;
            end else if (if_req_i) begin
                grant_if_s = 1'b1;
            end else begin
                grant_dm_s = 1'b0;
                grant_if_s = 1'b0;
            end
        end else begin
            grant_dm_s = 1'b0;
            grant_if_s = 1'b0;
        end
    end

    // Arbiter FSM with registered bus outputs and the fetch discard flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= ARB_IDLE;
            discard_r <= 1'b0;
            wb_cyc_r  <= 1'b0;
            wb_stb_r  <= 1'b0;
            wb_we_r   <= 1'b0;
            wb_sel_r  <= 4'h0;
            wb_adr_r  <= 32'h0000_0000;
            wb_dat_r  <= 32'h0000_0000;
        end else begin
            case (state_r)
                ARB_IDLE: begin
                    discard_r <= 1'b0;
                    if (grant_dm_s) begin
                        state_r  <= ARB_DM;
                        wb_cyc_r <= 1'b1;
                        wb_stb_r <= 1'b1;
                        wb_we_r  <= dm_we_i;
                        wb_sel_r <= dm_sel_i;
                        wb_adr_r <= dm_adr_i;
                        wb_dat_r <= dm_dat_i;
                    end else if (grant_if_s) begin
                        state_r  <= ARB_IF;
                        wb_cyc_r <= 1'b1;
                        wb_stb_r <= 1'b1;
                        wb_we_r  <= 1'b0;
                        wb_sel_r <= ARB_SEL_WORD;
                        wb_adr_r <= if_adr_i;
                        wb_dat_r <= 32'h0000_0000;
                    end else begin
                        state_r <= ARB_IDLE;
                    end
                end
                ARB_IF: begin
                    // A Wishbone cycle is never aborted; a flush only hides its ack
                    if (wb_ack_i) begin
                        state_r   <= ARB_IDLE;
                        wb_cyc_r  <= 1'b0;
                        wb_stb_r  <= 1'b0;
                        discard_r <= 1'b0;
                    end else if (flush_i) begin
                        discard_r <= 1'b1;
                    end else begin
                        discard_r <= discard_r;
                    end
                end
                ARB_DM: begin
                    if (wb_ack_i) begin
                        state_r  <= ARB_IDLE;
                        wb_cyc_r <= 1'b0;
                        wb_stb_r <= 1'b0;
                    end else begin
                        state_r <= ARB_DM;
                    end
                end
                default: begin
                    state_r   <= ARB_IDLE;
                    discard_r <= 1'b0;
                    wb_cyc_r  <= 1'b0;
                    wb_stb_r  <= 1'b0;
                end
            endcase
        end
    end

    assign wb_cyc_o = wb_cyc_r;
    assign wb_stb_o = wb_stb_r;
    assign wb_we_o  = wb_we_r;
    assign wb_sel_o = wb_sel_r;
    assign wb_adr_o = wb_adr_r;
    assign wb_dat_o = wb_dat_r;

    // Response path is combinational so a zero-wait slave completes in one cycle;
    // a flush in the ack cycle itself must also suppress the fetch ack.
    assign if_ack_o = wb_ack_i & (state_r == ARB_IF) & ~discard_r & ~flush_i;
    assign dm_ack_o = wb_ack_i & (state_r == ARB_DM);
    assign if_dat_o = wb_dat_i;
    assign dm_dat_o = wb_dat_i;

endmodule : cpu_mem_arbiter

// File: tb/tb_cpu_mem_arbiter.sv
module tb_cpu_mem_arbiter;

    localparam int unsigned LIMIT = 4;
`ifdef CPU_ARB_STARVE_GUARD_EN
    localparam int MODEL_LIMIT = LIMIT;
`else
    localparam int MODEL_LIMIT = 1000000;
`endif

    typedef struct {
        logic        is_if;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        logic        exp_ack;
    } txn_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        if_req_i = 1'b0;
    logic [31:0] if_adr_i = 32'h0;
    logic [31:0] if_dat_o;
    logic        if_ack_o;
    logic        flush_i = 1'b0;
    logic        dm_req_i = 1'b0;
    logic        dm_we_i = 1'b0;
    logic [3:0]  dm_sel_i = 4'h0;
    logic [31:0] dm_adr_i = 32'h0;
    logic [31:0] dm_dat_i = 32'h0;
    logic [31:0] dm_dat_o;
    logic        dm_ack_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i = 32'h0;
    logic        wb_ack_i = 1'b0;

    int          n_checks = 0;
    int          n_fail = 0;
    txn_t        exp_q[$];
    txn_t        if_list[$];
    txn_t        dm_list[$];
    int          slave_waits = 0;
    bit          slave_en = 1'b0;
    bit          slave_fix_en = 1'b0;
    logic [31:0] slave_fix_dat = 32'h0;
    logic [31:0] slave_dat = 32'h0;
    int          slave_wcnt = 0;

    cpu_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .if_req_i (if_req_i),
        .if_adr_i (if_adr_i),
        .if_dat_o (if_dat_o),
        .if_ack_o (if_ack_o),
        .flush_i  (flush_i),
        .dm_req_i (dm_req_i),
        .dm_we_i  (dm_we_i),
        .dm_sel_i (dm_sel_i),
        .dm_adr_i (dm_adr_i),
        .dm_dat_i (dm_dat_i),
        .dm_dat_o (dm_dat_o),
        .dm_ack_o (dm_ack_o),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_we_o  (wb_we_o),
        .wb_sel_o (wb_sel_o),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_dat_i (wb_dat_i),
        .wb_ack_i (wb_ack_i)
    );

    initial begin
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic txn_t mk_if(input logic [31:0] a);
        txn_t t;
        t.is_if = 1'b1; t.we = 1'b0; t.sel = 4'hF; t.adr = a; t.dat = 32'h0; t.exp_ack = 1'b1;
        return t;
    endfunction

    function automatic txn_t mk_dm(input logic we, input logic [3:0] sel,
                                   input logic [31:0] a, input logic [31:0] d);
        txn_t t;
        t.is_if = 1'b0; t.we = we; t.sel = sel; t.adr = a; t.dat = d; t.exp_ack = 1'b1;
        return t;
    endfunction

    // Slave: acks each bus cycle after slave_waits wait states with fresh data
    initial begin
        forever begin
            @(posedge clk_i); #1;
            if (slave_en) begin
                if (wb_ack_i) begin
                    wb_ack_i = 1'b0;
                    slave_wcnt = 0;
                end else if (wb_cyc_o && wb_stb_o) begin
                    if (slave_wcnt >= slave_waits) begin
                        wb_dat_i = slave_fix_en ? slave_fix_dat : $urandom;
                        slave_dat = wb_dat_i;
                        wb_ack_i = 1'b1;
                        slave_wcnt = 0;
                    end else begin
                        slave_wcnt++;
                    end
                end else begin
                    slave_wcnt = 0;
                end
            end else begin
                slave_wcnt = 0;
            end
        end
    end

    // Monitor: pops the expected transaction at each new bus cycle and checks acks
    initial begin
        bit   cyc_prev = 1'b0;
        bit   cur_valid = 1'b0;
        txn_t cur;
        int   ack_cnt = 0;
        forever begin
            @(negedge clk_i);
            if (wb_cyc_o === 1'b1 && !cyc_prev) begin
                ack_cnt = 0;
                if (exp_q.size() == 0) begin
                    check("unexpected_grant", {32'h0, wb_adr_o}, 64'hFFFF_FFFF_FFFF_FFFF);
                    cur_valid = 1'b0;
                end else begin
                    cur = exp_q.pop_front();
                    cur_valid = 1'b1;
                    check("grant_fields", {26'h0, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o},
                          {26'h0, 1'b1, cur.we, cur.sel, cur.adr});
                    if (cur.we) check("grant_wdata", {32'h0, wb_dat_o}, {32'h0, cur.dat});
                end
            end else if (wb_cyc_o === 1'b1 && cur_valid) begin
                check("bus_hold", {26'h0, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o},
                      {26'h0, 1'b1, cur.we, cur.sel, cur.adr});
            end
            if (if_ack_o === 1'b1) begin
                ack_cnt++;
                check("if_ack_owner", {61'h0, cur_valid, cur.is_if, cur.exp_ack}, 64'd7);
                check("if_dat", {32'h0, if_dat_o}, {32'h0, slave_dat});
            end
            if (dm_ack_o === 1'b1) begin
                ack_cnt++;
                check("dm_ack_owner", {62'h0, cur_valid, ~cur.is_if}, 64'd3);
                check("dm_dat", {32'h0, dm_dat_o}, {32'h0, slave_dat});
            end
            if (wb_cyc_o !== 1'b1 && cyc_prev && cur_valid) begin
                check("ack_count", 64'(ack_cnt), {63'h0, cur.exp_ack});
                cur_valid = 1'b0;
            end
            cyc_prev = (wb_cyc_o === 1'b1);
        end
    end

    task automatic wait_ack(input bit is_if);
        bit got = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk_i);
            if (is_if ? (if_ack_o === 1'b1) : (dm_ack_o === 1'b1)) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check(is_if ? "if_ack_timeout" : "dm_ack_timeout", 64'd0, 64'd1);
        @(posedge clk_i); #1;
    endtask

    task automatic wait_cyc();
        bit got = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk_i);
            if (wb_cyc_o === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("cyc_timeout", 64'd0, 64'd1);
    endtask

    // Run both requesters (each issuing its list back to back) against the model order
    task automatic run_round();
        int fi = 0;
        int di = 0;
        int starve = 0;
        int nf = if_list.size();
        int nd = dm_list.size();
        while (fi < nf || di < nd) begin
            if (di < nd && !(fi < nf && starve >= MODEL_LIMIT)) begin
                exp_q.push_back(dm_list[di]);
                di++;
                if (fi < nf) starve++; else starve = 0;
            end else begin
                exp_q.push_back(if_list[fi]);
                fi++;
                starve = 0;
            end
        end
        fork
            begin
                for (int i = 0; i < nf; i++) begin
                    if_adr_i = if_list[i].adr;
                    if_req_i = 1'b1;
                    wait_ack(1'b1);
                end
                if_req_i = 1'b0;
            end
            begin
                for (int j = 0; j < nd; j++) begin
                    dm_we_i  = dm_list[j].we;
                    dm_sel_i = dm_list[j].sel;
                    dm_adr_i = dm_list[j].adr;
                    dm_dat_i = dm_list[j].dat;
                    dm_req_i = 1'b1;
                    wait_ack(1'b0);
                end
                dm_req_i = 1'b0;
            end
        join
        if_list.delete();
        dm_list.delete();
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    // Fetch A gets flushed after `pre` cycles on the bus; redirected fetch B must ack
    task automatic flush_run(input int waits, input logic [31:0] a0, input logic [31:0] a1);
        txn_t t0;
        t0 = mk_if(a0);
        t0.exp_ack = 1'b0;
        slave_waits = waits;
        exp_q.push_back(t0);
        exp_q.push_back(mk_if(a1));
        if_adr_i = a0;
        if_req_i = 1'b1;
        wait_cyc();
        @(posedge clk_i); #1;
        flush_i = 1'b1;
        if_adr_i = a1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        wait_ack(1'b1);
        if_req_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t t;
        // Reset, with a stray bus ack present to prove the acks are state-gated
        wb_ack_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_bus_ctl", {61'h0, wb_cyc_o, wb_stb_o, wb_we_o}, 64'd0);
        check("rst_sel", {60'h0, wb_sel_o}, 64'd0);
        check("rst_adr_dat", {wb_adr_o, wb_dat_o}, 64'd0);
        check("rst_acks", {62'h0, if_ack_o, dm_ack_o}, 64'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check("idle_stray_ack", {61'h0, if_ack_o, dm_ack_o, wb_cyc_o}, 64'd0);
        @(posedge clk_i); #1;
        wb_ack_i = 1'b0;
        slave_en = 1'b1;

        // Single fetch, 2 wait states, fixed read data
        slave_waits = 2;
        slave_fix_en = 1'b1;
        slave_fix_dat = 32'hDEAD_BEEF;
        if_list.push_back(mk_if(32'h0000_1000));
        run_round();
        slave_fix_en = 1'b0;

        // Contention: data write wins, fetch follows
        slave_waits = 1;
        if_list.push_back(mk_if(32'h0000_3000));
        dm_list.push_back(mk_dm(1'b1, 4'h3, 32'h0000_2000, 32'hCAFE_F00D));
        run_round();

        // Flush mid-fetch (3 wait states) and flush in the ack cycle (1 wait state)
        flush_run(3, 32'h0000_4000, 32'h0000_4100);
        flush_run(1, 32'h0000_5000, 32'h0000_5100);

        // Flush in ARB_IDLE and in ARB_DM has no effect
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        if_list.push_back(mk_if(32'h0000_6000));
        run_round();
        slave_waits = 2;
        dm_list.push_back(mk_dm(1'b0, 4'h1, 32'h0000_7000, 32'h0));
        fork
            run_round();
            begin
                repeat (2) @(posedge clk_i);
                #1 flush_i = 1'b1;
                @(posedge clk_i); #1;
                flush_i = 1'b0;
            end
        join

        // Starvation: fetch and data both kept busy
        slave_waits = 0;
        for (int i = 0; i < 2; i++) if_list.push_back(mk_if(32'h0001_0000 + 32'(i * 4)));
        for (int i = 0; i < 10; i++)
            dm_list.push_back(mk_dm(1'(i % 2), 4'hF, 32'h0002_0000 + 32'(i * 4), $urandom));
        run_round();

        // Randomized rounds
        for (int r = 0; r < 20; r++) begin
            int nf;
            int nd;
            slave_waits = $urandom_range(0, 3);
            nf = $urandom_range(0, 3);
            nd = $urandom_range(0, 3);
            if (nf == 0 && nd == 0) nf = 1;
            for (int i = 0; i < nf; i++) if_list.push_back(mk_if($urandom & 32'hFFFF_FFFC));
            for (int i = 0; i < nd; i++)
                dm_list.push_back(mk_dm(1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)),
                                        $urandom, $urandom));
            run_round();
        end

        // Reset during ARB_DM, then a stray ack must not reach the data side
        slave_waits = 5;
        t = mk_dm(1'b1, 4'hC, 32'h0000_8000, 32'h1234_5678);
        t.exp_ack = 1'b0;
        exp_q.push_back(t);
        dm_we_i = t.we; dm_sel_i = t.sel; dm_adr_i = t.adr; dm_dat_i = t.dat;
        dm_req_i = 1'b1;
        wait_cyc();
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        slave_en = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        dm_req_i = 1'b0;
        check("rst_mid_cyc", {63'h0, wb_cyc_o}, 64'd0);
        @(posedge clk_i); #1;
        wb_ack_i = 1'b1;
        @(negedge clk_i);
        check("late_ack_ignored", {62'h0, dm_ack_o, if_ack_o}, 64'd0);
        @(posedge clk_i); #1;
        wb_ack_i = 1'b0;
        slave_en = 1'b1;

        // Recovery after reset
        slave_waits = 0;
        dm_list.push_back(mk_dm(1'b0, 4'hF, 32'h0000_9000, 32'h0));
        if_list.push_back(mk_if(32'h0000_A000));
        run_round();

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_cpu_mem_arbiter
